// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// State encoding is 3 bits so the debug port can be bound directly by checkers.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_HDR0  = 3'd0,
    ST_HDR1  = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

  localparam int CNT_W          = 16;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word packer: each accepted byte lands in lane byte_idx.
// o_word_next already contains the byte being accepted, so the 4th byte can be captured directly.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word_next,
  output logic        o_word_full
);

  logic [31:0]           r_word;
  logic [BYTE_IDX_W-1:0] r_idx;

  always_comb begin
    o_word_next = r_word;
    o_word_next[{r_idx, 3'b000} +: 8] = i_byte;
    o_word_full = i_accept && (r_idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (i_clear) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (i_accept) begin
      r_word <= o_word_next;
      r_idx  <= r_idx + BYTE_IDX_W'(1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: reads a 16-bit word-count header then little-endian words from a byte stream,
// writes them to instruction memory and holds the core until the image is complete.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = 45,
  parameter int ADDR_W = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  output logic              o_rx_ready,
  input  logic              i_reload,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_waddr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_core_hold,
  output logic              o_load_done,
  output logic              o_load_err,
  output state_e            o_dbg_state
);

  // Handshake: a byte moves on a rising edge where rx_valid and rx_ready are both high;
  // the source holds rx_data stable while valid is high and ready is low.

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_e            r_state, w_next;
  logic [CNT_W-1:0]  r_cnt, r_word_idx, w_hdr_cnt;
  logic              w_rx_ready, w_accept, w_clear, w_word_full, w_last;
  logic [31:0]       w_word_next;
  logic              r_mem_we, r_core_hold, r_load_done, r_load_err;
  logic [ADDR_W-1:0] r_mem_waddr;
  logic [31:0]       r_mem_wdata;

  assign w_rx_ready = !i_rst && (r_state inside {ST_HDR0, ST_HDR1, ST_DATA});
  assign w_accept   = i_rx_valid && w_rx_ready;
  assign w_hdr_cnt  = {i_rx_data, r_cnt[7:0]};
  assign w_last     = (r_word_idx == r_cnt - CNT_W'(1));

  imem_loader_byte_packer u_packer (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (w_clear),
    .i_accept    (w_accept && (r_state == ST_DATA)),
    .i_byte      (i_rx_data),
    .o_word_next (w_word_next),
    .o_word_full (w_word_full)
  );

  always_comb begin
    w_next  = r_state;
    w_clear = 1'b0;
    case (r_state)
      ST_HDR0: begin
        w_clear = 1'b1;
        if (w_accept) w_next = ST_HDR1;
      end
      ST_HDR1: begin
        w_clear = 1'b1;
        if (w_accept) begin
          if (w_hdr_cnt == '0)         w_next = ST_DONE;
          else if (w_hdr_cnt > DEPTH_C) w_next = ST_ERR;
          else                          w_next = ST_DATA;
        end
      end
      ST_DATA:  if (w_word_full) w_next = ST_WRITE;
      ST_WRITE: w_next = w_last ? ST_DONE : ST_DATA;
      ST_DONE:  if (i_reload) w_next = ST_HDR0;
      ST_ERR:   w_next = ST_ERR;
      default:  w_next = ST_HDR0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_HDR0;
      r_cnt      <= '0;
      r_word_idx <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept && r_state == ST_HDR0) r_cnt[7:0]  <= i_rx_data;
      if (w_accept && r_state == ST_HDR1) begin
        r_cnt[15:8] <= i_rx_data;
        r_word_idx  <= '0;
      end
      if (r_state == ST_WRITE && !w_last) r_word_idx <= r_word_idx + CNT_W'(1);
    end
  end

  // Outputs are registered from the next state so they change only on clock edges.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem_we    <= 1'b0;
      r_mem_waddr <= '0;
      r_mem_wdata <= '0;
      r_core_hold <= 1'b1;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_mem_we    <= (w_next == ST_WRITE);
      r_core_hold <= (w_next != ST_DONE);
      r_load_done <= (w_next == ST_DONE);
      r_load_err  <= r_load_err || (w_next == ST_ERR);
      if (w_word_full) begin
        r_mem_waddr <= r_word_idx[ADDR_W-1:0];
        r_mem_wdata <= w_word_next;
      end
    end
  end

  assign o_rx_ready  = w_rx_ready;
  assign o_mem_we    = r_mem_we;
  assign o_mem_waddr = r_mem_waddr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_core_hold = r_core_hold;
  assign o_load_done = r_load_done;
  assign o_load_err  = r_load_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: images are built as whole words, split into bytes for the stream,
// and the words themselves are queued as the expected memory writes.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int DEPTH  = 45;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              reload = 1'b0;
  logic              rx_ready, mem_we, core_hold, load_done, load_err;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  state_e            dbg_state;

  int checks   = 0;
  int failures = 0;
  int n_writes = 0;
  logic [ADDR_W+31:0] exp_q[$];
  logic [31:0]        img[$];

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rx_valid  (rx_valid),
    .i_rx_data   (rx_data),
    .o_rx_ready  (rx_ready),
    .i_reload    (reload),
    .o_mem_we    (mem_we),
    .o_mem_waddr (mem_waddr),
    .o_mem_wdata (mem_wdata),
    .o_core_hold (core_hold),
    .o_load_done (load_done),
    .o_load_err  (load_err),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- check helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out or unexpected event", name);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      logic [ADDR_W+31:0] e;
      n_writes++;
      check("rx_ready_in_write", {63'd0, rx_ready}, 64'd0);
      if (exp_q.size() == 0) begin
        fail("unexpected_write");
      end else begin
        e = exp_q.pop_front();
        check("write_addr", {58'd0, mem_waddr}, {58'd0, e[ADDR_W+31:32]});
        check("write_data", {32'd0, mem_wdata}, {32'd0, e[31:0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input bit toggle);
    int n;
    if (toggle) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    forever begin
      @(negedge clk);
      if (rx_ready) begin
        @(posedge clk);
        #1;
        break;
      end
      n++;
      if (n > 200) begin
        fail("handshake");
        break;
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!load_done && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_load_done"}, {63'd0, load_done}, 64'd1);
    check({name, "_core_hold"}, {63'd0, core_hold}, 64'd0);
    check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic load_img(input bit toggle, input string name);
    logic [15:0] n;
    logic [31:0] w;
    n = 16'(img.size());
    send_byte(n[7:0], toggle);
    send_byte(n[15:8], toggle);
    foreach (img[i]) begin
      w = img[i];
      exp_q.push_back({ADDR_W'(i), w});
      for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], toggle);
    end
    wait_done(name);
  endtask

  task automatic rand_img(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back($urandom);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
  endtask

  task automatic reload_from_done(input string name);
    pulse_reload();
    check({name, "_reload_hold"}, {63'd0, core_hold}, 64'd1);
    check({name, "_reload_done"}, {63'd0, load_done}, 64'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_we"},    {63'd0, mem_we}, 64'd0);
    check({name, "_waddr"}, {58'd0, mem_waddr}, 64'd0);
    check({name, "_wdata"}, {32'd0, mem_wdata}, 64'd0);
    check({name, "_hold"},  {63'd0, core_hold}, 64'd1);
    check({name, "_done"},  {63'd0, load_done}, 64'd0);
    check({name, "_err"},   {63'd0, load_err}, 64'd0);
    check({name, "_ready"}, {63'd0, rx_ready}, 64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    fail("watchdog");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int wr0;
    #12;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_reset", {63'd0, rx_ready}, 64'd1);

    // Fixed two-word image with valid held high.
    img = '{32'h04000413, 32'h03200493};
    wr0 = n_writes;
    load_img(1'b0, "fixed");
    check("fixed_write_count", 64'(n_writes - wr0), 64'd2);

    // Zero-length header.
    reload_from_done("zero");
    wr0 = n_writes;
    send_byte(8'h00, 1'b0);
    check("zero_not_done_early", {63'd0, load_done}, 64'd0);
    send_byte(8'h00, 1'b0);
    check("zero_done", {63'd0, load_done}, 64'd1);
    check("zero_release", {63'd0, core_hold}, 64'd0);
    check("zero_ready_low", {63'd0, rx_ready}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("zero_no_write", 64'(n_writes - wr0), 64'd0);

    // Same fixed image with random gaps on rx_valid.
    reload_from_done("toggle");
    img = '{32'h04000413, 32'h03200493};
    load_img(1'b1, "toggle");

    // Random images, random lengths.
    for (int t = 0; t < 4; t++) begin
      reload_from_done("rand");
      rand_img($urandom_range(1, 8));
      load_img(1'b1, "rand");
    end

    // Largest legal image.
    reload_from_done("full");
    rand_img(DEPTH);
    load_img(1'b0, "full");

    // Reload during DATA is ignored; reload in DONE restarts and overwrites addr0.
    reload_from_done("rl");
    img = '{32'hA5C3_1E77};
    exp_q.push_back({ADDR_W'(0), img[0]});
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(img[0][7:0], 1'b0);
    pulse_reload();
    check("rl_data_hold", {63'd0, core_hold}, 64'd1);
    check("rl_data_state", {61'd0, dbg_state}, {61'd0, ST_DATA});
    for (int b = 1; b < 4; b++) send_byte(img[0][8*b +: 8], 1'b1);
    wait_done("rl");
    reload_from_done("rl2");
    rand_img(1);
    load_img(1'b1, "rl2");

    // Reset in the middle of word 0 drops the partial word.
    reload_from_done("rst");
    wr0 = n_writes;
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_no_write", 64'(n_writes - wr0), 64'd0);
    rand_img(1);
    load_img(1'b0, "after_rst");

    // Oversized header enters the sticky error state.
    reload_from_done("err");
    wr0 = n_writes;
    send_byte(8'h2E, 1'b0);
    send_byte(8'h00, 1'b0);
    check("err_flag", {63'd0, load_err}, 64'd1);
    check("err_hold", {63'd0, core_hold}, 64'd1);
    check("err_ready", {63'd0, rx_ready}, 64'd0);
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("err_ready_stays_low", {63'd0, rx_ready}, 64'd0);
    end
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
    pulse_reload();
    check("err_sticky", {63'd0, load_err}, 64'd1);
    check("err_done_low", {63'd0, load_done}, 64'd0);
    check("err_no_write", 64'(n_writes - wr0), 64'd0);
    rst = 1'b1;
    #1;
    check("err_cleared_by_rst", {63'd0, load_err}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
